masked_share_gen: RTL and testbench

Sequential producer of masked operands for the masked Canright S-box datapath. Accepts plain bytes over a valid/ready handshake, masks each with a fresh byte from an internal 16-bit Galois LFSR, and emits the masked byte, its mask, and both in the 3-bit shared-factor format {sum, hi, lo} consumed by the masked GF(2^2) multipliers. It sits in front of the masked S-box and supplies every operand and mask share it uses.

---
 rtl/masked_share_gen_if.sv | 23 ++
 rtl/masked_share_gen.sv | 101 ++++++++++
 tb/tb_masked_share_gen.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/masked_share_gen_if.sv
// Handshake/data bundle between the plain-byte producer, masked_share_gen and the
// masked S-box consumer: input stream (in_*) and masked-output stream (out_*).
interface masked_share_gen_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_masked;
   logic [7:0]  out_mask;
   logic [11:0] out_sh_d;
   logic [11:0] out_sh_m;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_masked, out_mask, out_sh_d, out_sh_m
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_masked, out_mask, out_sh_d, out_sh_m
   );
endinterface

// File: rtl/masked_share_gen.sv
// Masks plain bytes with fresh LFSR bytes and emits {sum,hi,lo} shared-factor forms.
// Define MASKGEN_ZERO_MASK_EN for the debug build (mask forced to zero, LFSR still runs).
module masked_share_gen #(
   parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              seed_load_i,
   input  logic [15:0]       seed_i,
   masked_share_gen_if.slave bus
);

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   logic [15:0] lfsr_q, lfsr_d;
   logic        out_valid_q, out_valid_d;
   logic [7:0]  out_masked_q, out_masked_d;
   logic [7:0]  out_mask_q, out_mask_d;
   logic [11:0] out_sh_d_q, out_sh_d_d;
   logic [11:0] out_sh_m_q, out_sh_m_d;
   logic        in_ready;
   logic        accept;
   logic [7:0]  mask_sel;
   logic [7:0]  masked_sel;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

   // Each bit pair {v[2k+1], v[2k]} becomes the triple {sum, hi, lo}.
   function automatic logic [11:0] share_enc(input logic [7:0] v);
      logic [11:0] r;
      r = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         r[3*k +: 3] = {v[2*k+1] ^ v[2*k], v[2*k+1], v[2*k]};
      end
      return r;
   endfunction

`ifdef MASKGEN_ZERO_MASK_EN
   assign mask_sel = '0;
`else
   assign mask_sel = lfsr_q[7:0];
`endif

   assign masked_sel = bus.in_data ^ mask_sel;
   assign in_ready   = !seed_load_i && (!out_valid_q || bus.out_ready);
   assign accept     = bus.in_valid && in_ready;

   always_comb begin
      lfsr_d       = lfsr_q;
      out_valid_d  = out_valid_q;
      out_masked_d = out_masked_q;
      out_mask_d   = out_mask_q;
      out_sh_d_d   = out_sh_d_q;
      out_sh_m_d   = out_sh_m_q;

      // Seed load blocks acceptance through in_ready, so the two branches are exclusive.
      if (seed_load_i) begin
         lfsr_d = (seed_i == 16'h0000) ? SEED_DEFAULT : seed_i;
      end else if (accept) begin
         lfsr_d = lfsr_step(lfsr_q);
      end

      if (accept) begin
         out_valid_d  = 1'b1;
         out_masked_d = masked_sel;
         out_mask_d   = mask_sel;
         out_sh_d_d   = share_enc(masked_sel);
         out_sh_m_d   = share_enc(mask_sel);
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q       <= SEED_DEFAULT;
         out_valid_q  <= 1'b0;
         out_masked_q <= '0;
         out_mask_q   <= '0;
         out_sh_d_q   <= '0;
         out_sh_m_q   <= '0;
      end else begin
         lfsr_q       <= lfsr_d;
         out_valid_q  <= out_valid_d;
         out_masked_q <= out_masked_d;
         out_mask_q   <= out_mask_d;
         out_sh_d_q   <= out_sh_d_d;
         out_sh_m_q   <= out_sh_m_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_masked = out_masked_q;
   assign bus.out_mask   = out_mask_q;
   assign bus.out_sh_d   = out_sh_d_q;
   assign bus.out_sh_m   = out_sh_m_q;

endmodule

// File: tb/tb_masked_share_gen.sv
// Directed bench for masked_share_gen: reset, transfer, backpressure, seed load,
// streaming against an LFSR reference, and asynchronous reset mid-stream.
module tb_masked_share_gen;

`ifdef MASKGEN_ZERO_MASK_EN
   localparam bit ZM = 1'b1;
`else
   localparam bit ZM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        seed_load = 1'b0;
   logic [15:0] seed = '0;
   logic [15:0] ref_lfsr;
   logic [7:0]  em;

   int n_assert = 0;
   int n_fail = 0;

   masked_share_gen_if bus ();

   masked_share_gen #(.SEED_DEFAULT(16'hACE1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .seed_load_i(seed_load),
      .seed_i     (seed),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] mexp(input logic [7:0] m);
      return ZM ? 8'h00 : m;
   endfunction

   function automatic logic [15:0] lfsr_model(input logic [15:0] s);
      logic [15:0] r;
      r = s >> 1;
      if (s[0]) r = r ^ 16'hB400;
      return r;
   endfunction

   function automatic logic [11:0] enc_model(input logic [7:0] v);
      logic [11:0] r;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         r[3*k]   = v[2*k];
         r[3*k+1] = v[2*k+1];
         r[3*k+2] = v[2*k] ^ v[2*k+1];
      end
      return r;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      // Reset state
      #12;
      chk("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
      chk("rst_out_masked", {8'd0, bus.out_masked}, 16'd0);
      chk("rst_out_mask", {8'd0, bus.out_mask}, 16'd0);
      chk("rst_sh_d", {4'd0, bus.out_sh_d}, 16'd0);
      chk("rst_sh_m", {4'd0, bus.out_sh_m}, 16'd0);
      chk("rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
      @(negedge clk) rst_n = 1'b1;

      // First transfer: mask E1
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = 8'h53; bus.out_ready = 1'b1;
      tick();
      chk("t1_valid", {15'd0, bus.out_valid}, 16'd1);
      chk("t1_mask", {8'd0, bus.out_mask}, {8'd0, ZM ? 8'h00 : 8'hE1});
      chk("t1_masked", {8'd0, bus.out_masked}, {8'd0, ZM ? 8'h53 : 8'hB2});
      chk("t1_sh_d", {4'd0, bus.out_sh_d}, {4'd0, ZM ? 12'hB43 : 12'hCC6});
      chk("t1_sh_m", {4'd0, bus.out_sh_m}, {4'd0, ZM ? 12'h000 : 12'h785});

      // Backpressure for 5 cycles
      @(negedge clk);
      bus.out_ready = 1'b0; bus.in_data = 8'hAA;
      #1 chk("bp_in_ready", {15'd0, bus.in_ready}, 16'd0);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("bp_valid", {15'd0, bus.out_valid}, 16'd1);
         chk("bp_masked", {8'd0, bus.out_masked}, {8'd0, ZM ? 8'h53 : 8'hB2});
         chk("bp_mask", {8'd0, bus.out_mask}, {8'd0, ZM ? 8'h00 : 8'hE1});
         chk("bp_in_ready_hold", {15'd0, bus.in_ready}, 16'd0);
      end

      // Release: simultaneous take and accept, mask 70
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1 chk("rel_in_ready", {15'd0, bus.in_ready}, 16'd1);
      tick();
      chk("rel_valid", {15'd0, bus.out_valid}, 16'd1);
      chk("rel_mask", {8'd0, bus.out_mask}, {8'd0, ZM ? 8'h00 : 8'h70});
      chk("rel_masked", {8'd0, bus.out_masked}, {8'd0, ZM ? 8'hAA : 8'hDA});
      chk("rel_sh_m", {4'd0, bus.out_sh_m}, {4'd0, ZM ? 12'h000 : 12'hAC0});

      // Drain: valid drops, data holds
      @(negedge clk) bus.in_valid = 1'b0;
      tick();
      chk("drain_valid", {15'd0, bus.out_valid}, 16'd0);
      chk("drain_hold", {8'd0, bus.out_masked}, {8'd0, ZM ? 8'hAA : 8'hDA});

      // LFSR now 7138: mask 38
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = 8'h0F;
      tick();
      chk("t3_mask", {8'd0, bus.out_mask}, {8'd0, ZM ? 8'h00 : 8'h38});
      chk("t3_masked", {8'd0, bus.out_masked}, {8'd0, ZM ? 8'h0F : 8'h37});

      // Zero seed load with input pending and output stalled
      @(negedge clk);
      bus.out_ready = 1'b0; seed_load = 1'b1; seed = 16'h0000; bus.in_data = 8'h11;
      #1 chk("sl0_in_ready", {15'd0, bus.in_ready}, 16'd0);
      tick();
      chk("sl0_valid_kept", {15'd0, bus.out_valid}, 16'd1);
      chk("sl0_out_kept", {8'd0, bus.out_masked}, {8'd0, ZM ? 8'h0F : 8'h37});
      @(negedge clk);
      seed_load = 1'b0; bus.out_ready = 1'b1;
      tick();
      chk("sl0_mask", {8'd0, bus.out_mask}, {8'd0, ZM ? 8'h00 : 8'hE1});
      chk("sl0_masked", {8'd0, bus.out_masked}, {8'd0, ZM ? 8'h11 : 8'hF0});

      // Seed 1234 load with in_valid high: load wins
      @(negedge clk);
      seed_load = 1'b1; seed = 16'h1234; bus.in_data = 8'h00;
      #1 chk("sl1_in_ready", {15'd0, bus.in_ready}, 16'd0);
      tick();
      chk("sl1_no_accept", {15'd0, bus.out_valid}, 16'd0);
      chk("sl1_hold", {8'd0, bus.out_masked}, {8'd0, ZM ? 8'h11 : 8'hF0});
      @(negedge clk) seed_load = 1'b0;
      tick();
      chk("sl1_mask", {8'd0, bus.out_mask}, {8'd0, ZM ? 8'h00 : 8'h34});
      chk("sl1_masked", {8'd0, bus.out_masked}, {8'd0, ZM ? 8'h00 : 8'h34});

      // Streaming 256 bytes against the reference LFSR (state 091A after 1234)
      ref_lfsr = 16'h091A;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1; bus.in_data = i[7:0]; bus.out_ready = 1'b1;
         #1 chk("str_in_ready", {15'd0, bus.in_ready}, 16'd1);
         tick();
         em = mexp(ref_lfsr[7:0]);
         chk("str_valid", {15'd0, bus.out_valid}, 16'd1);
         chk("str_unmask", {8'd0, bus.out_masked ^ bus.out_mask}, {8'd0, i[7:0]});
         chk("str_mask", {8'd0, bus.out_mask}, {8'd0, em});
         chk("str_sh_d", {4'd0, bus.out_sh_d}, {4'd0, enc_model(i[7:0] ^ em)});
         chk("str_sh_m", {4'd0, bus.out_sh_m}, {4'd0, enc_model(em)});
         ref_lfsr = lfsr_model(ref_lfsr);
      end
      @(negedge clk) bus.in_valid = 1'b0;

      // Async reset while stalled
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = 8'h5A; bus.out_ready = 1'b0;
      tick();
      chk("ar_pre_valid", {15'd0, bus.out_valid}, 16'd1);
      @(negedge clk) bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid_drop", {15'd0, bus.out_valid}, 16'd0);
      chk("ar_masked_clr", {8'd0, bus.out_masked}, 16'd0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = 8'h53; bus.out_ready = 1'b1;
      tick();
      chk("ar_mask", {8'd0, bus.out_mask}, {8'd0, ZM ? 8'h00 : 8'hE1});
      chk("ar_masked", {8'd0, bus.out_masked}, {8'd0, ZM ? 8'h53 : 8'hB2});
      @(negedge clk) bus.in_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
